// File: rtl/ser_tx4_if.sv
// Handshake and serial-line bundle for ser_tx4.
// The master side supplies words; the slave side (the transmitter) drives the line and status.
interface ser_tx4_if #(
   parameter int unsigned WIDTH = 4
);
   logic             en;
   logic             load;
   logic [WIDTH-1:0] d;
   logic             ready;
   logic             busy;
   logic             tx;
   logic             done;

   modport master (output en, load, d, input ready, busy, tx, done);
   modport slave  (input en, load, d, output ready, busy, tx, done);
endinterface

// File: rtl/ser_tx4.sv
// Parallel-in, serial-out transmitter: start bit (low), WIDTH data bits LSB-first, stop bit (high).
// All outputs are registered; en freezes every register except the single-cycle done pulse.
module ser_tx4 #(
   parameter int unsigned WIDTH        = 4,
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   ser_tx4_if.slave    bus
);
   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [WIDTH-1:0]  shreg_q, shreg_d;
   logic [WIDTH-1:0]  shreg_shift;
   logic              tx_q, tx_d;
   logic              done_q, done_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              bit_end;
   logic              last_bit;

   assign shreg_shift = shreg_q >> 1;
   assign bit_end     = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
   assign last_bit    = (bit_q == BIT_W'(WIDTH - 1));

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      tx_d    = tx_q;
      done_d  = 1'b0;

      if (bus.en) begin
         if (state_q != S_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
         end
         case (state_q)
            S_IDLE: begin
               tx_d = 1'b1;
               if (bus.load) begin
                  shreg_d = bus.d;
                  baud_d  = '0;
                  tx_d    = 1'b0;
                  state_d = S_START;
               end
            end
            S_START: begin
               if (bit_end) begin
                  tx_d    = shreg_q[0];
                  bit_d   = '0;
                  state_d = S_DATA;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  if (last_bit) begin
                     tx_d    = 1'b1;
                     state_d = S_STOP;
                  end else begin
                     shreg_d = shreg_shift;
                     tx_d    = shreg_shift[0];
                     bit_d   = bit_q + BIT_W'(1);
                  end
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      ready_d = (state_d == S_IDLE);
      busy_d  = ~ready_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.tx    = tx_q;
   assign bus.done  = done_q;
   assign bus.ready = ready_q;
   assign bus.busy  = busy_q;
endmodule

// File: tb/tb_ser_tx4.sv
// Bench for ser_tx4: two instances (CLKS_PER_BIT=4 and 1) share stimulus and are each
// compared every cycle against a frame-level model (line bit = frame[enabled_cycles / CLKS_PER_BIT]).
module tb_ser_tx4;
   localparam int unsigned W = 4;

   logic         clk   = 1'b0;
   logic         reset = 1'b1;
   logic         en    = 1'b0;
   logic         load  = 1'b0;
   logic [W-1:0] d     = '0;

   ser_tx4_if #(.WIDTH(W)) if0 ();
   ser_tx4_if #(.WIDTH(W)) if1 ();

   assign if0.en   = en;
   assign if0.load = load;
   assign if0.d    = d;
   assign if1.en   = en;
   assign if1.load = load;
   assign if1.d    = d;

   ser_tx4 #(.WIDTH(W), .CLKS_PER_BIT(4)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
   ser_tx4 #(.WIDTH(W), .CLKS_PER_BIT(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Frame-level reference: n counts enabled cycles since accept; frame lasts (W+2)*cpb of them.
   int           cpb    [2] = '{4, 1};
   bit           m_busy [2] = '{1'b0, 1'b0};
   bit           m_done [2] = '{1'b0, 1'b0};
   int           m_n    [2] = '{0, 0};
   logic [W-1:0] m_word [2];

   function automatic logic exp_tx(input int i);
      int idx;
      if (!m_busy[i]) return 1'b1;
      idx = m_n[i] / cpb[i];
      if (idx == 0) return 1'b0;
      if (idx <= int'(W)) return m_word[i][idx-1];
      return 1'b1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_busy[i] = 1'b0;
         m_done[i] = 1'b0;
         m_n[i]    = 0;
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         m_done[i] = 1'b0;
         if (reset) begin
            m_busy[i] = 1'b0;
            m_n[i]    = 0;
         end else if (en) begin
            if (!m_busy[i]) begin
               if (load) begin
                  m_busy[i] = 1'b1;
                  m_word[i] = d;
                  m_n[i]    = 0;
               end
            end else begin
               m_n[i]++;
               if (m_n[i] == (int'(W) + 2) * cpb[i]) begin
                  m_busy[i] = 1'b0;
                  m_done[i] = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic check_dut(input int i, input logic tx, input logic rdy, input logic bsy,
                            input logic dn);
      chk($sformatf("tx%0d", i),    32'(tx),  32'(exp_tx(i)));
      chk($sformatf("ready%0d", i), 32'(rdy), 32'(!m_busy[i]));
      chk($sformatf("busy%0d", i),  32'(bsy), 32'(m_busy[i]));
      chk($sformatf("done%0d", i),  32'(dn),  32'(m_done[i]));
   endtask

   task automatic check_all();
      check_dut(0, if0.tx, if0.ready, if0.busy, if0.done);
      check_dut(1, if1.tx, if1.ready, if1.busy, if1.done);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   // Asynchronous reset raised between edges; line must go high before the next edge.
   task automatic async_reset();
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      cyc();
      reset = 1'b0;
   endtask

   int c, t0, t1;
   bit found;

   initial begin
      cyc();
      cyc();
      reset = 1'b0;
      en    = 1'b1;
      repeat (10) cyc();

      // Single frame 4'hA, latency to done for both baud settings
      d = 4'hA; load = 1'b1;
      cyc();
      load = 1'b0;
      t0 = -1; t1 = -1;
      for (int k = 1; k <= 40; k++) begin
         cyc();
         if (if0.done && t0 < 0) t0 = k;
         if (if1.done && t1 < 0) t1 = k;
      end
      chk("lat_c4", 32'(t0), 32'd24);
      chk("lat_c1", 32'(t1), 32'd6);

      // Back-to-back: second load presented in the done cycle
      d = 4'h3; load = 1'b1;
      cyc();
      load = 1'b0;
      c = 0; found = 1'b0;
      while (c < 40 && !found) begin
         cyc();
         c++;
         if (if0.done) found = 1'b1;
      end
      chk("b2b_done", 32'(c), 32'd24);
      d = 4'hC; load = 1'b1;
      cyc();
      c++;
      load = 1'b0;
      chk("b2b_gap", 32'(c), 32'd25);
      chk("b2b_start", 32'(if0.tx), 32'd0);
      repeat (30) cyc();

      // en toggling during a frame; load held while busy must be ignored
      d = 4'h9; load = 1'b1;
      cyc();
      for (int k = 0; k < 60; k++) begin
         en   = k[0];
         load = (k < 40);
         d    = 4'($urandom);
         cyc();
      end
      en = 1'b1; load = 1'b0;
      repeat (10) cyc();

      // One-cycle bits on the CLKS_PER_BIT=1 instance
      d = 4'hF; load = 1'b1;
      cyc();
      load = 1'b0;
      repeat (30) cyc();

      // Reset 7 cycles into DATA, then a clean frame
      d = 4'h6; load = 1'b1;
      cyc();
      load = 1'b0;
      repeat (11) cyc();
      async_reset();
      chk("rst_tx", 32'(if0.tx), 32'd1);
      repeat (3) cyc();
      d = 4'h5; load = 1'b1;
      cyc();
      load = 1'b0;
      repeat (30) cyc();

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         en   = ($urandom_range(0, 3) != 0);
         load = ($urandom_range(0, 2) == 0);
         d    = 4'($urandom);
         if ($urandom_range(0, 199) == 0) async_reset();
         else cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ser_tx4.md
# ser_tx4

Parallel-in, serial-out transmitter for the flip-flop library. It accepts a WIDTH-bit word from a register stage through a load/ready handshake. It then shifts the word out LSB-first on a single line, framed by one start bit (low) and one stop bit (high). It is the sending end of the serial link whose receiving end captures bits back into an enabled, async-reset register bank.

## Interface
- WIDTH, 4, data bits per frame (≥1)
- CLKS_PER_BIT, 4, enabled clock cycles per serial bit (≥1)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- en  in  1  clock enable; when low, the FSM, counters, shift register and tx hold
- load  in  1  request to send d; accepted when load & ready & en at a rising edge
- d  in  WIDTH  parallel word, sampled only on the accept edge
- ready  out  1  high only in IDLE; block can accept a word
- busy  out  1  high in START, DATA and STOP
- tx  out  1  registered serial line; idles high
- done  out  1  one-clk pulse after the stop bit completes

## Operation
- Reset values: state=IDLE, tx=1, ready=1, busy=0, done=0, shift register=0, bit counter=0, baud counter=0.
- States: IDLE → START → DATA → STOP → IDLE.
- IDLE:
  - tx=1.
  - On accept: shift register ← d, baud counter ← 0, tx ← 0, state ← START.
- START: tx=0 for CLKS_PER_BIT enabled cycles, then tx ← shift register[0], bit counter ← 0, state ← DATA.
- DATA:
  - Each bit is held for CLKS_PER_BIT enabled cycles.
  - At the end of each bit the shift register shifts right by one and tx ← the next LSB.
  - After bit WIDTH-1: tx ← 1, state ← STOP.
- STOP: tx=1 for CLKS_PER_BIT enabled cycles, then state ← IDLE and done ← 1.
- Baud counter:
  - Width is clog2(CLKS_PER_BIT), minimum 1.
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - With CLKS_PER_BIT=1, every enabled cycle is a bit boundary.
- Bit counter: width clog2(WIDTH), minimum 1; no wrap within a frame.
- en low:
  - All registers hold, including tx and the position within the current bit.
  - load is ignored.
  - done still clears on the next clk edge; it is never stretched.
- Changes to d after the accept edge have no effect on the frame in flight.
- load while busy: ignored, not queued; no error.
- Reset mid-frame: tx returns high asynchronously and the frame is aborted; no done pulse is issued.

## Timing
- Accept at edge k: tx=0 visible from edge k; ready=0 and busy=1 from edge k.
- Each bit occupies exactly CLKS_PER_BIT enabled cycles.
- Start of data bit i (0-based): edge k + (1+i)·CLKS_PER_BIT.
- Start of stop bit: edge k + (1+WIDTH)·CLKS_PER_BIT.
- Return to IDLE: edge k + (WIDTH+2)·CLKS_PER_BIT, with en held high throughout.
  - At that edge ready=1, busy=0, done=1 for one cycle.
- Back-to-back frames:
  - load may be accepted in the done cycle.
  - Minimum frame period is (WIDTH+2)·CLKS_PER_BIT + 1 cycles, giving at least one idle-high cycle between frames.
- ready and busy are complementary at every cycle.
- tx is a registered output with no combinational path from any input.
- done is never high while busy=1.

## Test plan
- Reset, then idle for 10 cycles → tx=1, ready=1, busy=0, done=0 throughout.
- WIDTH=4, CLKS_PER_BIT=4, en=1; load d=4'b1010 → tx holds 0,0,1,0,1,1 in 4-cycle blocks; done pulses exactly 24 cycles after accept; ready=1 at that edge.
- Back-to-back: load d=4'h3, then assert load in the done cycle with d=4'hC → second start bit begins 25 cycles after the first accept; serial data is 1,1,0,0 then 0,0,1,1.
- en toggled 1/0 alternately during a frame with d=4'h9 → each bit lasts 8 clks; bit values are unchanged (LSB-first 1,0,0,1); load while busy is ignored.
- Assert reset 7 cycles into DATA → tx=1 immediately, ready=1, no done pulse; a new load of 4'h5 afterwards transmits a clean frame.
- CLKS_PER_BIT=1, d=4'hF → frame 0,1,1,1,1,1, one cycle per bit; done 6 cycles after accept.
